// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Load/store bus between the pipeline core (master) and the data-memory
// responder (slave).
//   req_valid / req_ready : request handshake, master -> slave
//   req_we                : 1 = store, 0 = load
//   req_addr              : 32-bit word address
//   req_wdata             : store data
//   resp_valid/resp_ready : response handshake, slave -> master
//   resp_rdata            : load data (0 for stores and errors)
//   resp_err              : address was out of range
// -----------------------------------------------------------------------------
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Word-addressed data memory sitting behind a valid/ready request channel and
// a valid/ready response channel. One transaction is outstanding at a time;
// each access is delayed by WAIT_STATES cycles after the request is accepted.
// Out-of-range addresses are flagged with resp_err and never touch memory.
//   clk       : clock, all state on posedge
//   RN        : asynchronous active-high reset (also clears the memory)
//   bus       : slave side of dmem_responder_if
//   txn_count : completed response handshakes, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 RN,
    dmem_responder_if.slave      bus,
    output logic [CNT_W-1:0]     txn_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS_M1 = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [CNT_W-1:0]  txn_count_q, txn_count_d;

    logic [31:0]       mem_q [DEPTH];

    // Access operands: with zero wait states the access happens on the accept
    // edge itself, so the live bus inputs are used; otherwise the captured copy.
    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic              acc_in_range;
    logic [AW-1:0]     acc_idx;
    logic              do_access;
    logic              mem_we;

    always_comb begin
        if (state_q == IDLE) begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
        // Full 32-bit compare: high address bits must not alias into the array.
        acc_in_range = (acc_addr < 32'(DEPTH));
        acc_idx      = acc_addr[AW-1:0];
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        txn_count_d  = txn_count_q;
        do_access    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d        = bus.req_we;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    req_ready_d = 1'b0;
                    if (WAIT_STATES == 0) begin
                        do_access    = 1'b1;
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end else begin
                        cnt_d   = WS_M1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    do_access    = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // req_ready rises on the handshake edge, so a new request can
                // only be accepted on the following edge.
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    txn_count_d  = txn_count_q + 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_access) begin
            resp_err_d   = !acc_in_range;
            resp_rdata_d = (!acc_we && acc_in_range) ? mem_q[acc_idx] : 32'd0;
        end
    end

    assign mem_we = do_access && acc_we && acc_in_range;

    always_ff @(posedge clk or posedge RN) begin
        if (RN) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            txn_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            txn_count_q  <= txn_count_d;
        end
    end

    // Reset wipes the whole array so bring-up always starts from known data.
    always_ff @(posedge clk or posedge RN) begin
        if (RN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (mem_we) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign txn_count      = txn_count_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Word-addressed data-memory responder: the target end of the pipeline core's load/store path.
- Replaces the core's direct array access with a valid/ready request channel and a valid/ready response channel.
- Inserts a programmable number of wait states per access.
- Flags out-of-range addresses and counts completed transactions for bring-up.

Parameters:
DEPTH, 32, number of 32-bit words; word address range 0..DEPTH-1
WAIT_STATES, 2, extra cycles between request accept and response (0..15)
CNT_W, 16, width of completed-transaction counter

Ports:
clk  input  1  single clock; all state updates on posedge
RN  input  1  reset, asynchronous, active-high
req_valid  input  1  initiator presents a request
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store (SW), 0 = load (LW)
req_addr  input  32  word address
req_wdata  input  32  store data
resp_valid  output  1  response available
resp_ready  input  1  initiator accepts response
resp_rdata  output  32  load data; 0 for stores and errors
resp_err  output  1  address >= DEPTH
txn_count  output  CNT_W  completed response handshakes, wraps

Behaviour:
- Reset (RN=1, asynchronous):
  - FSM to IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; txn_count=0.
  - Wait counter=0; all DEPTH memory words cleared to 0.
  - Any in-flight request is dropped with no memory side effect.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept edge E0 is any edge with req_valid=1. Capture we/addr/wdata at E0.
  - If WAIT_STATES=0, go to RESP and perform the access at E0. Otherwise load counter with WAIT_STATES-1 and go to WAIT.
- WAIT:
  - req_ready=0. Decrement the counter each edge.
  - At the edge where the counter equals 0, perform the access and go to RESP.
  - resp_valid therefore rises exactly at edge E0+WAIT_STATES.
- Access at the RESP-entry edge:
  - Load, in range: resp_rdata = mem[addr], resp_err=0.
  - Store, in range: mem[addr] <= wdata, resp_rdata=0, resp_err=0.
  - addr >= DEPTH (full 32-bit compare, no wrap or truncation): no memory read or write, resp_rdata=0, resp_err=1.
- RESP:
  - resp_valid=1, req_ready=0. resp_rdata and resp_err held stable while resp_ready=0 (indefinite stall allowed).
  - Edge with resp_ready=1: go to IDLE, resp_valid=0, txn_count+1 (modulo 2^CNT_W; all-ones wraps to 0).
  - resp_rdata and resp_err keep their last value after the handshake.
- Throughput: one transaction per WAIT_STATES+2 cycles at best. No request is accepted in the cycle a response completes; req_ready returns in the cycle after.
- Read-after-write: a load accepted after a store's response has completed returns the new data. There is no other ordering concern, since only one transaction is outstanding.
- Inputs req_we, req_addr and req_wdata are ignored outside IDLE and may change freely after E0.
- If req_valid drops in WAIT or RESP, nothing changes; no cancellation exists.
- RN asserted in WAIT or RESP: immediate return to the reset state. A store that has not yet reached its access edge leaves memory unchanged; memory is cleared regardless.

Test Plan:
- Reset then load addr 5, WAIT_STATES=2 -> req_ready=1 after reset; resp_valid rises 2 edges after accept; resp_rdata=0x00000000, resp_err=0; txn_count=1.
- Store 0xDEADBEEF to addr 3, then load addr 3 -> store response rdata=0, err=0; load returns 0xDEADBEEF; txn_count=2.
- Load addr 32 and addr 0xFFFFFFFF (DEPTH=32) -> resp_err=1, rdata=0; prior contents of addr 0 (set to 0x1234) unchanged on readback.
- Hold resp_ready=0 for 7 cycles during a load of addr 3 -> resp_valid, rdata and err stable all 7 cycles; req_ready=0 throughout; single txn_count increment on release.
- Assert RN one cycle after accepting store 0x55 to addr 7 -> outputs reset immediately; a subsequent load of addr 7 returns 0; txn_count=0.
- WAIT_STATES=0 build, back-to-back requests with resp_ready tied 1 -> response one edge after each accept; accepts spaced 2 cycles; drive CNT_W=4 for 17 transactions -> txn_count wraps to 1.
